// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;
  localparam int W_DEF    = 4;
  localparam int DIV_STOP = 0;
  localparam int DIV_BYP  = 1;

  // High-phase length of a D-cycle period: ceil(D/2). Widened so D=2**W-1 cannot wrap.
  function automatic logic [31:0] half_hi(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction
endpackage

// File: rtl/clk_divider_multi_if.sv
// Divisor request / divided-clock status bundle for clk_divider_multi.
interface clk_divider_multi_if #(
  parameter int NUM_CH = 4,
  parameter int W      = clk_div_pkg::W_DEF
);
  logic [NUM_CH-1:0][W-1:0] div_i;
  logic                     sync_i;
  logic [NUM_CH-1:0]        clk_o;
  logic [NUM_CH-1:0]        tick_o;
  logic [NUM_CH-1:0]        pend_o;

  modport master (output div_i, sync_i, input clk_o, tick_o, pend_o);
  modport slave  (input div_i, sync_i, output clk_o, tick_o, pend_o);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, boundary-only divisor load, and the
// glitch-safe bypass mux feeding clk_in straight through when D=1.
module clk_div_cmux (
  input  logic clk_a,
  input  logic clk_b,
  input  logic sel,
  output logic clk_o
);
  // Stand-in for the library clock-mux cell; keep as its own hierarchy.
  assign clk_o = sel ? clk_b : clk_a;
endmodule

module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic [W-1:0] div_i,
  input  logic         sync_i,
  output logic         clk_o,
  output logic         tick_o,
  output logic         pend_o
);
  logic [W-1:0] cnt, div_act, cnt_nxt, div_nxt;
  logic         out_r, tick_r, byp_r, bnd;

  always_comb begin
    bnd     = (div_act <= W'(DIV_BYP)) || sync_i || (cnt == div_act - W'(1));
    div_nxt = bnd ? div_i : div_act;
    cnt_nxt = bnd ? '0 : cnt + W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      div_act <= '0;
      out_r   <= 1'b0;
      tick_r  <= 1'b0;
      byp_r   <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      div_act <= div_nxt;
      byp_r   <= (div_nxt == W'(DIV_BYP));
      tick_r  <= (div_nxt != W'(DIV_STOP)) && (cnt_nxt == '0);
      // out_r stays high in bypass so leaving bypass never drops a half-cycle.
      if (div_nxt == W'(DIV_STOP))     out_r <= 1'b0;
      else if (div_nxt == W'(DIV_BYP)) out_r <= 1'b1;
      else                             out_r <= (32'(cnt_nxt) < half_hi(32'(div_nxt)));
    end
  end

  assign tick_o = tick_r;
  assign pend_o = (div_i != div_act);

  clk_div_cmux u_cmux (.clk_a(out_r), .clk_b(clk_in), .sel(byp_r), .clk_o(clk_o));
endmodule

// File: rtl/clk_divider_multi.sv
// NUM_CH independent programmable clock dividers sharing clk_in and a common phase-align sync.
module clk_divider_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int W      = W_DEF
) (
  input  logic               clk_in,
  input  logic               rst_n,
  clk_divider_multi_if.slave bus
);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    clk_div_ch #(.W(W)) u_ch (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .div_i  (bus.div_i[k]),
      .sync_i (bus.sync_i),
      .clk_o  (bus.clk_o[k]),
      .tick_o (bus.tick_o[k]),
      .pend_o (bus.pend_o[k])
    );
  end
endmodule
